// File: rtl/dcache_fill_ctrl_pkg.sv
// dcache_fill_ctrl_pkg
//   Shared definitions for the data-cache miss fill controller.
//   - state_t         : controller state encoding (IDLE / FILL / META)
//   - WORDS_PER_BLOCK : words in one cache line
//   - OFFSET_W        : byte-offset bits inside a line (line alignment)
//   - WORD_IDX_W      : width of the word slot index inside a line
//   - IC_W            : width of the issue counter, which must reach 8
package dcache_fill_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_META = 2'b10
    } state_t;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_W        = 4;
    localparam int WORD_IDX_W      = 3;
    localparam int IC_W            = WORD_IDX_W + 1;

endpackage

// File: rtl/dcache_fill_ctrl_fill_counter.sv
// fill_counter
//   Width-W up-counter with enable, synchronous clear and a saturation flag.
//   The count holds once it reaches MAX_VAL; clear has priority over enable.
//   Ports:
//     clk   : clock, rising edge
//     rst   : asynchronous active-low reset, clears the count
//     en    : count up by one this cycle (ignored while saturated)
//     clr   : synchronous clear to zero
//     count : current count value
//     sat   : high when count equals MAX_VAL
module fill_counter #(
    parameter int           W       = 4,
    parameter logic [W-1:0] MAX_VAL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = (count == MAX_VAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/dcache_fill_ctrl.sv
// dcache_fill_ctrl
//   Services a data-cache miss: issues one read per cycle for every word of the
//   aligned line, writes each returned word into the data array with its slot
//   index, then pulses the metadata write and drops the stall.
//   Optional build macro: DCACHE_FILL_PERF_CNT_EN adds miss_count and
//   stall_cycles saturating performance counters.
//   Ports:
//     clk, rst           : clock and asynchronous active-low reset
//     miss_detected      : level miss request from the cache
//     miss_address       : missing byte address
//     memory_data(_valid): read return from main memory, in issue order
//     memory_en          : read request strobe
//     memory_address     : read request address (word aligned)
//     fill_data          : word written into the data array
//     fill_word_idx      : word slot within the line
//     write_data_array   : data-array write enable
//     write_tag_array    : metadata write enable (one cycle per fill)
//     fsm_busy           : pipeline stall request
//     miss_count         : (perf build) number of fills started
//     stall_cycles       : (perf build) number of busy cycles
module dcache_fill_ctrl
    import dcache_fill_ctrl_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LAT         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_W-1:0]     miss_address,
    input  logic [DATA_W-1:0]     memory_data,
    input  logic                  memory_data_valid,
    output logic                  memory_en,
    output logic [ADDR_W-1:0]     memory_address,
    output logic [DATA_W-1:0]     fill_data,
    output logic [WORD_IDX_W-1:0] fill_word_idx,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic                  fsm_busy
`ifdef DCACHE_FILL_PERF_CNT_EN
    ,
    output logic [15:0]           miss_count,
    output logic [15:0]           stall_cycles
`endif
);

    state_t                  state;
    logic [ADDR_W-1:0]       base;
    logic [IC_W-1:0]         ic;
    logic [WORD_IDX_W-1:0]   rc;
    logic                    ic_sat;
    logic                    rc_sat;
    logic                    in_fill;
    logic                    last_return;
    logic                    ctr_clr;
    logic                    unused_addr_bits;

    // The line offset bits never reach the request path; base is line aligned.
    assign unused_addr_bits = ^miss_address[OFFSET_W-1:0];

    assign in_fill     = (state == ST_FILL);
    assign last_return = in_fill && memory_data_valid && rc_sat;
    // Counters are cleared on the cycle that enters META and held at zero
    // whenever no fill is running.
    assign ctr_clr     = last_return || !in_fill;

    fill_counter #(
        .W       (IC_W),
        .MAX_VAL (IC_W'(WORDS_PER_BLOCK))
    ) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (in_fill && !ic_sat),
        .clr   (ctr_clr),
        .count (ic),
        .sat   (ic_sat)
    );

    fill_counter #(
        .W       (WORD_IDX_W),
        .MAX_VAL (WORD_IDX_W'(WORDS_PER_BLOCK - 1))
    ) u_return_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (in_fill && memory_data_valid),
        .clr   (ctr_clr),
        .count (rc),
        .sat   (rc_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            base  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_detected) begin
                        base  <= {miss_address[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (last_return) begin
                        state <= ST_META;
                    end
                end
                ST_META: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from state and counters only; returns seen outside FILL
    // are dropped, which covers stale data still in flight after a reset.
    assign memory_en        = in_fill && !ic_sat;
    assign memory_address   = memory_en ? (base + ADDR_W'({ic, 1'b0})) : '0;
    assign write_data_array = in_fill && memory_data_valid;
    assign fill_data        = write_data_array ? memory_data : '0;
    assign fill_word_idx    = write_data_array ? rc : '0;
    assign write_tag_array  = (state == ST_META);
    assign fsm_busy         = (state != ST_IDLE);

    // Every accepted return must match a request issued MEM_LAT cycles earlier.
    a_return_latency: assert property (@(posedge clk) disable iff (!rst)
        write_data_array |-> $past(memory_en, MEM_LAT));

`ifdef DCACHE_FILL_PERF_CNT_EN
    logic miss_sat;
    logic stall_sat;

    fill_counter #(.W(16)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    ((state == ST_IDLE) && miss_detected && !miss_sat),
        .clr   (1'b0),
        .count (miss_count),
        .sat   (miss_sat)
    );

    fill_counter #(.W(16)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (fsm_busy && !stall_sat),
        .clr   (1'b0),
        .count (stall_cycles),
        .sat   (stall_sat)
    );
`endif

endmodule
